// File: rtl/key_code_gen_if.sv
// Key inputs and code outputs of key_code_gen, bundled for the board or bench side
// (master) and the generator side (slave).
interface key_code_gen_if;
  logic key_step;
  logic key_mode;
  logic code_out1;
  logic code_out2;
  logic code_out3;
  logic code_vld;
  logic auto_on;

  modport master (
    output key_step, key_mode,
    input  code_out1, code_out2, code_out3, code_vld, auto_on
  );

  modport slave (
    input  key_step, key_mode,
    output code_out1, code_out2, code_out3, code_vld, auto_on
  );
endinterface

// File: rtl/key_code_gen.sv
// Debounced two-key select-code generator for the 3-to-8 decoder (manual step / timed auto step).
// Optional macro SKIP_CODE7_EN: the code runs 0..6 and never drives 3'b111.
module key_code_gen #(
  parameter logic [19:0] CNT_MAX  = 20'd999_999,
  parameter logic [24:0] AUTO_MAX = 25'd24_999_999
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  key_code_gen_if.slave bus
);

  localparam int KEY_STEP = 0;
  localparam int KEY_MODE = 1;

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } state_t;

  logic [1:0]  w_key_raw;
  logic [1:0]  r_key_meta;
  logic [1:0]  r_key_sync;
  logic [19:0] r_db_cnt [2];
  logic [1:0]  w_flag;

  state_t      r_state;
  logic [24:0] r_auto_cnt;
  logic [2:0]  r_code;
  logic        r_code_vld;
  logic        r_auto_on;
  logic        w_tick;
  logic        w_step_ev;
  logic [2:0]  w_code_nxt;

  assign w_key_raw = {bus.key_mode, bus.key_step};

  // Sync flops reset to the released level, so a key held through reset must
  // still serve a full debounce before it can flag.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  // NOTE: the two debounce counters are plain flops, not a RAM, so they take the reset too.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_key_meta <= 2'b11;
      r_key_sync <= 2'b11;
      for (int k = 0; k < 2; k++) r_db_cnt[k] <= '0;
    end else begin
      r_key_meta <= w_key_raw;
      r_key_sync <= r_key_meta;
      for (int k = 0; k < 2; k++) begin
        if (r_key_sync[k])
          r_db_cnt[k] <= '0;
        else if (r_db_cnt[k] != CNT_MAX)
          r_db_cnt[k] <= r_db_cnt[k] + 20'd1;
      end
    end
  end

  // NOTE: default assignment first so no path through always_comb can infer a latch.
  always_comb begin
    w_flag = '0;
    for (int k = 0; k < 2; k++)
      w_flag[k] = ~r_key_sync[k] && (r_db_cnt[k] == CNT_MAX - 20'd1);
  end

  assign w_tick    = (r_state == AUTO) && (r_auto_cnt == AUTO_MAX);
  assign w_step_ev = w_flag[KEY_STEP] || w_tick;

`ifdef SKIP_CODE7_EN
  assign w_code_nxt = (r_code >= 3'd6) ? 3'd0 : r_code + 3'd1;
`else
  assign w_code_nxt = r_code + 3'd1;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= MANUAL;
      r_auto_cnt <= '0;
      r_code     <= 3'd0;
      r_code_vld <= 1'b0;
      r_auto_on  <= 1'b0;
    end else begin
      r_code_vld <= w_step_ev;
      if (w_step_ev) r_code <= w_code_nxt;

      // A tick coinciding with the mode flag has already been counted above.
      case (r_state)
        MANUAL: begin
          r_auto_cnt <= '0;
          if (w_flag[KEY_MODE]) begin
            r_state   <= AUTO;
            r_auto_on <= 1'b1;
          end
        end
        AUTO: begin
          if (w_flag[KEY_MODE]) begin
            r_state    <= MANUAL;
            r_auto_on  <= 1'b0;
            r_auto_cnt <= '0;
          end else if (w_step_ev) begin
            r_auto_cnt <= '0;
          end else begin
            r_auto_cnt <= r_auto_cnt + 25'd1;
          end
        end
        default: begin
          r_state    <= MANUAL;
          r_auto_on  <= 1'b0;
          r_auto_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.code_out1 = r_code[2];
  assign bus.code_out2 = r_code[1];
  assign bus.code_out3 = r_code[0];
  assign bus.code_vld  = r_code_vld;
  assign bus.auto_on   = r_auto_on;

endmodule

// File: tb/tb_key_code_gen.sv
// Self-checking bench for key_code_gen: event-level reference model plus directed
// key sequences with hand-computed latencies (CNT_MAX=10, AUTO_MAX=20).
module tb_key_code_gen;

  localparam int CM = 10;
  localparam int AM = 20;
`ifdef SKIP_CODE7_EN
  localparam int MOD = 7;
`else
  localparam int MOD = 8;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  key_code_gen_if bus ();

  key_code_gen #(.CNT_MAX(20'd10), .AUTO_MAX(25'd20)) u_dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;
  int vld_pulses = 0;
  bit cmp_en = 1'b0;

  logic [2:0] dut_code;
  assign dut_code = {bus.code_out1, bus.code_out2, bus.code_out3};

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] next_code(input logic [2:0] c);
    return 3'((int'(c) + 1) % MOD);
  endfunction

  // Reference model: a key flags once when it has been seen low for CM
  // consecutive samples; the flag acts two edges later (synchronizer delay).
  // Auto ticks fire AM+1 edges after the last restart of the auto period.
  logic [2:0] m_code;
  logic       m_vld;
  logic       m_auto;
  int         m_run [2];
  logic [1:0] m_pipe0, m_pipe1;
  longint     m_edge, m_restart;

  always @(posedge sys_clk or negedge sys_rst_n) begin : model
    logic [1:0] keys;
    logic [1:0] fl;
    int         nr;
    longint     cur;
    bit         tick;
    bit         step;
    if (!sys_rst_n) begin
      m_code    <= 3'd0;
      m_vld     <= 1'b0;
      m_auto    <= 1'b0;
      m_run[0]  <= 0;
      m_run[1]  <= 0;
      m_pipe0   <= 2'b00;
      m_pipe1   <= 2'b00;
      m_edge    <= 0;
      m_restart <= 0;
    end else begin
      keys = {bus.key_mode, bus.key_step};
      fl   = m_pipe1;
      for (int k = 0; k < 2; k++) begin
        nr = (keys[k] == 1'b0) ? m_run[k] + 1 : 0;
        m_run[k]   <= nr;
        m_pipe0[k] <= (nr == CM);
      end
      m_pipe1 <= m_pipe0;
      cur  = m_edge + 1;
      tick = m_auto && (cur - m_restart == AM + 1);
      step = fl[0] || tick;
      m_vld <= step;
      if (step) m_code <= next_code(m_code);
      if ((!m_auto && fl[1]) || (m_auto && step)) m_restart <= cur;
      m_auto <= m_auto ^ fl[1];
      m_edge <= cur;
    end
  end

  always @(negedge sys_clk) begin
    if (cmp_en) begin
      check("outputs{code,vld,auto}",
            int'({dut_code, bus.code_vld, bus.auto_on}),
            int'({m_code, m_vld, m_auto}));
      if (bus.code_vld === 1'b1) vld_pulses++;
    end
  end

  // Counts rising edges (first one numbered 'start') until the condition holds;
  // returns -1 if the budget runs out.
  task automatic edges_until(input int sel, input int start, output int n);
    bit hit;
    hit = 1'b0;
    n   = -1;
    for (int k = start; k <= 60; k++) begin
      @(posedge sys_clk);
      #1;
      case (sel)
        0:       hit = (bus.code_vld === 1'b1);
        1:       hit = (bus.auto_on === 1'b1);
        default: hit = (bus.auto_on === 1'b0);
      endcase
      if (hit) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic press_step(input int hold);
    @(negedge sys_clk);
    bus.key_step = 1'b0;
    repeat (hold) @(negedge sys_clk);
    bus.key_step = 1'b1;
    repeat (4) @(negedge sys_clk);
  endtask

  logic [2:0] exp_code;
  int n, base;

  initial begin
    bus.key_step = 1'b1;
    bus.key_mode = 1'b1;
    sys_rst_n    = 1'b0;
    repeat (3) @(negedge sys_clk);
    cmp_en = 1'b1;
    check("reset_code", int'(dut_code), 0);
    check("reset_vld", int'(bus.code_vld), 0);
    check("reset_auto_on", int'(bus.auto_on), 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (100) @(negedge sys_clk);
    check("idle_code", int'(dut_code), 0);
    check("idle_vld_pulses", vld_pulses, 0);

    // Bounce: short lows never reach the hold count, the final hold flags once.
    for (int i = 0; i < 4; i++) begin
      bus.key_step = 1'b0;
      repeat (5) @(negedge sys_clk);
      bus.key_step = 1'b1;
      repeat (3) @(negedge sys_clk);
    end
    base = vld_pulses;
    bus.key_step = 1'b0;
    repeat (11) @(posedge sys_clk);
    #1 check("bounce_edge11_code", int'(dut_code), 0);
    @(posedge sys_clk);
    #1 check("bounce_edge12_code", int'(dut_code), 1);
    check("bounce_edge12_vld", int'(bus.code_vld), 1);
    @(posedge sys_clk);
    #1 check("bounce_edge13_vld", int'(bus.code_vld), 0);
    @(negedge sys_clk);
    bus.key_step = 1'b1;
    repeat (20) @(negedge sys_clk);
    check("bounce_pulses", vld_pulses - base, 1);
    exp_code = 3'd1;

    // Manual wrap: MOD presses walk the full sequence back to 1.
    base = vld_pulses;
    for (int i = 0; i < MOD; i++) begin
      press_step(14);
      exp_code = 3'((2 + i) % MOD);
      check("manual_code", int'(dut_code), int'(exp_code));
    end
    check("manual_pulses", vld_pulses - base, MOD);
    check("manual_final_code", int'(dut_code), 1);

    // Auto mode: entry 12 edges after press, then one step every 21 edges.
    @(negedge sys_clk);
    bus.key_mode = 1'b0;
    edges_until(1, 1, n);
    check("auto_entry_latency", n, 12);
    @(negedge sys_clk);
    bus.key_mode = 1'b1;
    edges_until(0, 1, n);
    check("auto_first_period", n, 21);
    edges_until(0, 1, n);
    check("auto_second_period", n, 21);
    exp_code = next_code(next_code(exp_code));
    check("auto_code", int'(dut_code), int'(exp_code));

    @(negedge sys_clk);
    bus.key_mode = 1'b0;
    edges_until(2, 1, n);
    check("auto_exit_latency", n, 12);
    @(negedge sys_clk);
    bus.key_mode = 1'b1;
    base = vld_pulses;
    repeat (60) @(negedge sys_clk);
    check("manual_no_auto_steps", vld_pulses - base, 0);
    check("manual_code_held", int'(dut_code), int'(exp_code));

    // Step flag aligned with the tick: one increment, period restarts.
    @(negedge sys_clk);
    bus.key_mode = 1'b0;
    edges_until(1, 1, n);
    check("auto2_entry_latency", n, 12);
    @(negedge sys_clk);
    bus.key_mode = 1'b1;
    repeat (9) @(posedge sys_clk);
    @(negedge sys_clk);
    bus.key_step = 1'b0;
    base = vld_pulses;
    edges_until(0, 10, n);
    check("aligned_step_edge", n, 21);
    exp_code = next_code(exp_code);
    check("aligned_single_inc", int'(dut_code), int'(exp_code));
    @(posedge sys_clk);
    #1 check("aligned_vld_one_cycle", int'(bus.code_vld), 0);
    @(negedge sys_clk);
    bus.key_step = 1'b1;
    edges_until(0, 2, n);
    check("aligned_next_period", n, 21);
    check("aligned_pulses", vld_pulses - base, 1);

    // Async reset mid-AUTO with the step key held down.
    @(negedge sys_clk);
    bus.key_step = 1'b0;
    repeat (3) @(posedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    check("async_rst_code", int'(dut_code), 0);
    check("async_rst_vld", int'(bus.code_vld), 0);
    check("async_rst_auto_on", int'(bus.auto_on), 0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (11) @(posedge sys_clk);
    #1 check("post_rst_edge11_code", int'(dut_code), 0);
    @(posedge sys_clk);
    #1 check("post_rst_edge12_code", int'(dut_code), 1);
    check("post_rst_edge12_vld", int'(bus.code_vld), 1);
    @(negedge sys_clk);
    bus.key_step = 1'b1;
    repeat (10) @(negedge sys_clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/key_code_gen.md
Name: key_code_gen

Overview:
- Upstream stage of the 3-to-8 one-hot decoder. Produces the 3-bit select code on code_out1/2/3, which connect directly to the decoder's in1/in2/in3.
- Code source is two debounced board keys. key_step advances the code by one. key_mode toggles between manual stepping and timed auto-stepping.
- Gives the LED/decoder path a clean, registered, glitch-free select.

Parameters:
- CNT_MAX, 20'd999_999: debounce hold count. 20 ms at 50 MHz. Minimum legal value 2.
- AUTO_MAX, 25'd24_999_999: auto-step period minus 1. 0.5 s at 50 MHz. Minimum legal value 1.

Ports:
- sys_clk, input, 1: system clock. All logic is on the rising edge.
- sys_rst_n, input, 1: reset, asynchronous, active-low.
- key_step, input, 1: raw step key, active-low, asynchronous to sys_clk.
- key_mode, input, 1: raw mode key, active-low, asynchronous to sys_clk.
- code_out1, output, 1: code bit 2 (MSB). Drives decoder in1.
- code_out2, output, 1: code bit 1. Drives decoder in2.
- code_out3, output, 1: code bit 0 (LSB). Drives decoder in3.
- code_vld, output, 1: one-cycle pulse in the first cycle a new code is visible.
- auto_on, output, 1: high while in AUTO state.

Behaviour:
- Reset (sys_rst_n low, asynchronous assert, synchronous release):
  - code = 3'b000, code_vld = 0, auto_on = 0, state = MANUAL.
  - Debounce and auto counters cleared; synchronizer flops set to 1 (released).
- Key synchronizer and debounce, one independent instance per key:
  - Two-flop synchronizer; the second flop gives the synced level.
  - Synced level high: debounce counter cleared to 0.
  - Synced level low: counter increments, saturating at CNT_MAX.
  - Press flag is combinational: high for exactly one cycle, when synced level is low and counter == CNT_MAX-1.
  - Releasing before CNT_MAX-1 is reached produces no flag. Holding the key produces only one flag; a new flag requires release then a full re-press.
- Latency: numbering the first edge that samples the key low as edge 1, the code (or state) update lands on edge CNT_MAX+2.
- State machine, MANUAL <-> AUTO:
  - mode flag toggles the state. auto_on is registered and equals (state == AUTO).
  - On entry to AUTO the auto counter is cleared to 0.
  - In MANUAL the auto counter is held at 0.
  - In AUTO the auto counter counts 0..AUTO_MAX and wraps to 0. The tick is asserted when counter == AUTO_MAX.
- Step event = step flag OR (AUTO and tick).
  - On a step event: code <= code + 1, with wrap rule per Optional Feature. code_vld <= 1 on the same edge; otherwise code_vld <= 0.
  - A step flag in AUTO also restarts the auto counter at 0.
- Simultaneous events:
  - Step flag and tick in the same cycle: exactly one increment.
  - Mode flag and step flag in the same cycle: the state toggles and the code increments once.
  - Mode flag toggling AUTO -> MANUAL in the same cycle as a tick: the tick is honoured (one increment), then the state goes to MANUAL.
- Outputs: code_out1/2/3 are driven straight from the code register, with no combinational path from the keys. All outputs are registered.
- Reset mid-operation: returns immediately to the reset values. A key held low through reset release must complete a full CNT_MAX debounce before any flag is produced.

Optional Feature:
- Macro: SKIP_CODE7_EN.
- Defined: code sequence is 0..6 and wraps 6 -> 0. Code 3'b111 is never driven, so the downstream decoder never sees its unhandled input. If 3'b111 is somehow present it is treated as 6 (next value is 0).
- Undefined: full 3-bit wrap, 0..7, then 7 -> 0.

Test Plan (bench uses CNT_MAX=10, AUTO_MAX=20):
- Reset check: hold sys_rst_n low, then release -> code=000, code_vld=0, auto_on=0. No change for 100 cycles with both keys high.
- Bounce rejection: toggle key_step low for 5 cycles / high for 3 cycles, 4 times, then hold low -> exactly one increment to 001. It lands on edge 12 after the first sampled-low edge of the final hold. code_vld is high for 1 cycle.
- Manual wrap, macro off: 8 clean presses -> codes 1,2,...,7,0, one code_vld pulse each. With SKIP_CODE7_EN: 7 presses -> 1,...,6,0.
- Auto mode: press key_mode -> auto_on=1, then the code increments every 21 cycles. Press key_mode again -> auto_on=0 and increments stop.
- Simultaneous events: in AUTO, align the step flag with the tick -> single increment and a single code_vld pulse; the next auto step comes 21 cycles later.
- Async reset mid-AUTO with key_step held low -> all outputs return to reset values immediately. After release, the held key yields one increment 12 edges after release.
